imem_program_loader: RTL and testbench
======================================

// Module: imem_program_loader
// PURPOSE
//  FIFO-to-instruction-memory program loader: the writer side of the instruction memory load port.
//  On start, it drains up to DEPTH 32-bit instruction words from the upstream synchronous FIFO.
//  Each word is written into instruction memory at consecutive byte addresses (step 4) through data_in/dir/we.
//  It holds the processor stopped (cpu_run=0) while loading and releases it when the image is complete.
// PARAMETERS
//  DEPTH      8        number of instruction words per program image (memory rows)
//  DATA_W     32       instruction word width
//  ADDR_W     32       byte-address width driven on mem_dir
//  BASE_ADDR  32'h0    byte address of first word; must be 4-byte aligned
// PORTS
//  clk          in   1       single clock; all state on posedge
//  rst_n        in   1       asynchronous, active-low reset
//  start        in   1       1-cycle pulse: begin loading a new image
//  fifo_empty   in   1       upstream FIFO has no word available
//  fifo_rd_en   out  1       pop request to FIFO; data valid on fifo_data the following cycle
//  fifo_data    in   DATA_W  FIFO read data (registered output of FIFO)
//  mem_we       out  1       instruction memory write enable
//  mem_dir      out  ADDR_W  instruction memory byte write address
//  mem_data_in  out  DATA_W  instruction word to write
//  busy         out  1       high in LOAD/DRAIN
//  done         out  1       high in DONE (image fully written)
//  cpu_run      out  1       processor release; high only in DONE
//  words_loaded out  $clog2(DEPTH+1)  count of words written in the current load
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; fifo_rd_en=0, mem_we=0, mem_dir=BASE_ADDR, mem_data_in=0,
//    busy=0, done=0, cpu_run=0, words_loaded=0; issued/written counters cleared.
//  FSM states: IDLE, LOAD, DRAIN, DONE.
//   IDLE : start=1 -> LOAD; counters cleared.
//   LOAD : fifo_rd_en = !fifo_empty && (issued < DEPTH), combinational; issued++ on each rd_en.
//          When issued reaches DEPTH -> DRAIN.
//   DRAIN: wait for the last outstanding write; when written==DEPTH -> DONE.
//   DONE : done=1, cpu_run=1; start=1 -> LOAD (cpu_run drops the next cycle; counters cleared).
//  Write pipeline: pend <= fifo_rd_en (registered).
//   mem_we = pend; mem_data_in = fifo_data; mem_dir = BASE_ADDR + (written << 2).
//   written++ on each mem_we. Latency is exactly 1 cycle from rd_en to the matching mem_we.
//  Addresses are contiguous regardless of FIFO empty gaps; a gap only stalls, never skips an address.
//  fifo_rd_en never asserts while fifo_empty=1, outside LOAD, or after DEPTH pops: no over-pop.
//  start in LOAD/DRAIN is ignored (no restart, no counter change).
//  Arithmetic: mem_dir computed in ADDR_W bits, unsigned; with the BASE_ADDR alignment rule, bits [1:0] are always 0.
//  words_loaded = written; it holds its final value (DEPTH) in DONE until the next start.
//  Reset mid-load: everything returns to reset values immediately.
//   No partial-image completion; the next start reloads from BASE_ADDR.
//   FIFO contents are the upstream's responsibility.
// STRUCTURE
//  Shared package (imem_pkg): loader_state_t enum {IDLE,LOAD,DRAIN,DONE}; IMEM_DEPTH=8;
//    INSTR_W=32; WORD_BYTES=4 (also consumed by the instruction memory and PC logic).
//  Single module, no sub-modules: FSM + two counters + one pending flag.
// TESTING
//  1 Reset: assert rst_n=0 mid-cycle -> all outputs at reset values asynchronously; cpu_run=0.
//  2 Full load, FIFO never empty, words 0xA0..0xA7, start at cycle 0:
//    rd_en cycles 1-8; we cycles 2-9 at dir 0,4,...,28 with data A0..A7.
//    done=cpu_run=1 from cycle 10; words_loaded=8.
//  3 FIFO empty for 3 cycles after word 2 -> rd_en low during the gap; word 3 still at dir 12.
//    No writes during the gap; total writes = 8.
//  4 FIFO holds 10 words -> exactly 8 pops; 2 words remain in the FIFO; no rd_en in DRAIN/DONE.
//  5 start pulsed during LOAD -> ignored; addresses continue monotonically; single done.
//  6 rst_n low after 4 writes, then start -> reload from dir 0 (BASE_ADDR); cpu_run stays 0 until 8 new writes.
//    Also from DONE: start -> cpu_run low the next cycle, then a new load.

Source files
------------

// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
//   Definitions shared by the instruction memory, the PC logic and the
//   program loader.
//   - loader_state_t : program loader FSM states
//   - IMEM_DEPTH     : instruction words per program image (memory rows)
//   - INSTR_W        : instruction word width in bits
//   - WORD_BYTES     : bytes per instruction word (byte-address step)
// -----------------------------------------------------------------------------
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  localparam int IMEM_DEPTH = 8;
  localparam int INSTR_W    = 32;
  localparam int WORD_BYTES = 4;

endpackage : imem_pkg

// File: rtl/imem_program_loader.sv
// -----------------------------------------------------------------------------
// imem_program_loader
//   Writer side of the instruction memory load port. On a start pulse it pops
//   DEPTH words from the upstream synchronous FIFO and writes them to
//   consecutive word addresses starting at BASE_ADDR. The processor is held
//   (cpu_run=0) until the whole image has been written.
//
// Ports
//   clk          : clock, all state on the rising edge
//   rst_n        : asynchronous active-low reset
//   start        : one-cycle pulse, begin loading a new image (IDLE/DONE only)
//   fifo_empty   : upstream FIFO has no word available
//   fifo_rd_en   : pop request; FIFO data valid on fifo_data the next cycle
//   fifo_data    : FIFO registered read data
//   mem_we       : instruction memory write enable
//   mem_dir      : instruction memory byte write address
//   mem_data_in  : instruction word to write
//   busy         : loader in LOAD or DRAIN
//   done         : image fully written
//   cpu_run      : processor release, high only while done
//   words_loaded : words written in the current load
// -----------------------------------------------------------------------------
module imem_program_loader
  import imem_pkg::*;
#(
  parameter int                DEPTH     = IMEM_DEPTH,
  parameter int                DATA_W    = INSTR_W,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [DATA_W-1:0]          fifo_data,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_dir,
  output logic [DATA_W-1:0]          mem_data_in,
  output logic                       busy,
  output logic                       done,
  output logic                       cpu_run,
  output logic [$clog2(DEPTH+1)-1:0] words_loaded
);

  localparam int                CNT_W      = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ONE_C      = CNT_W'(1);
  localparam int                WORD_SHIFT = $clog2(WORD_BYTES);

  loader_state_t    state_q, state_d;
  logic [CNT_W-1:0] issued_q, issued_d;    // pops requested this load
  logic [CNT_W-1:0] written_q, written_d;  // words written this load
  logic             pend_q;                // a popped word is on fifo_data now

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      issued_q  <= '0;
      written_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      written_q <= written_d;
      pend_q    <= fifo_rd_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and pop control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    written_d  = written_q;
    fifo_rd_en = 1'b0;

    // Every pending word is written this cycle, whatever the state.
    if (pend_q) begin
      written_d = written_q + ONE_C;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          issued_d  = '0;
          written_d = '0;
        end
      end

      LOAD: begin
        // Pop is gated by the issue count so the FIFO is never over-drained.
        fifo_rd_en = !fifo_empty && (issued_q < DEPTH_C);
        if (fifo_rd_en) begin
          issued_d = issued_q + ONE_C;
        end
        if (issued_d == DEPTH_C) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        // Look at the post-write count so done rises right after the last write.
        if (written_d == DEPTH_C) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (start) begin
          state_d   = LOAD;
          issued_d  = '0;
          written_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write port and status
  // ---------------------------------------------------------------------------
  assign mem_we       = pend_q;
  // Gated so the data bus is quiet (zero) whenever no write is in progress.
  assign mem_data_in  = pend_q ? fifo_data : '0;
  // Address follows the write count, so FIFO gaps stall but never skip a row.
  assign mem_dir      = BASE_ADDR + (ADDR_W'(written_q) << WORD_SHIFT);
  assign busy         = (state_q == LOAD) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign cpu_run      = (state_q == DONE);
  assign words_loaded = written_q;

endmodule : imem_program_loader

// File: tb/tb_imem_program_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_program_loader
//   Drives imem_program_loader from a queue-like FIFO model and checks every
//   cycle against a transaction-level model of the load: words come out of
//   the FIFO in order, each pop produces one write one cycle later at
//   BASE + 4*index, and the loader is done once DEPTH writes have happened.
// -----------------------------------------------------------------------------
module tb_imem_program_loader;
  import imem_pkg::*;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_data = 32'h0;
  logic        mem_we;
  logic [31:0] mem_dir;
  logic [31:0] mem_data_in;
  logic        busy;
  logic        done;
  logic        cpu_run;
  logic [3:0]  words_loaded;

  always #5 clk = ~clk;

  imem_program_loader #(
    .DEPTH(DEPTH), .DATA_W(32), .ADDR_W(32), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data),
    .mem_we(mem_we), .mem_dir(mem_dir), .mem_data_in(mem_data_in),
    .busy(busy), .done(done), .cpu_run(cpu_run), .words_loaded(words_loaded)
  );

  // ---------------- upstream FIFO model (registered read data) --------------
  logic [31:0] fq [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  bit          gap = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr) || gap;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= fq[rd_ptr % 1024];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [31:0] w);
    fq[wr_ptr % 1024] = w;
    wr_ptr++;
  endtask

  // ---------------- comparison bookkeeping ----------------------------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare -------------------
  bit          started = 1'b0;
  int          pops = 0;
  int          writes = 0;
  bit          prev_rd = 1'b0;
  logic [31:0] expq[$];
  int          cyc = 0;
  int          load_cyc = 0;
  int          nwe = 0;
  int          nrd = 0;
  int          rd_first = -1;
  int          done_rel = -1;
  int          we_rel  [16];
  logic [31:0] we_dir  [16];
  logic [31:0] we_data [16];

  always @(negedge clk) begin
    #1;
    cyc++;
    if (!rst_n) begin
      started = 1'b0; pops = 0; writes = 0; prev_rd = 1'b0;
      expq.delete();
      chk("rst_rd_en",   32'(fifo_rd_en),   32'd0);
      chk("rst_we",      32'(mem_we),       32'd0);
      chk("rst_dir",     mem_dir,           BASE);
      chk("rst_data",    mem_data_in,       32'd0);
      chk("rst_busy",    32'(busy),         32'd0);
      chk("rst_done",    32'(done),         32'd0);
      chk("rst_cpu_run", 32'(cpu_run),      32'd0);
      chk("rst_words",   32'(words_loaded), 32'd0);
    end else begin
      bit e_busy;
      bit e_done;
      e_busy = started && (writes < DEPTH);
      e_done = started && (writes == DEPTH);
      chk("busy",    32'(busy),         32'(e_busy));
      chk("done",    32'(done),         32'(e_done));
      chk("cpu_run", 32'(cpu_run),      32'(e_done));
      chk("words",   32'(words_loaded), 32'(writes));
      chk("rd_en",   32'(fifo_rd_en),   32'(started && pops < DEPTH && !fifo_empty));
      chk("we",      32'(mem_we),       32'(prev_rd));
      if (mem_we) begin
        logic [31:0] ed;
        ed = (expq.size() > 0) ? expq.pop_front() : 32'hDEAD_BEEF;
        chk("dir",  mem_dir,     BASE + 32'(writes * WORD_BYTES));
        chk("data", mem_data_in, ed);
        $display("write #%0d cyc=%0d dir=%h data=%h", writes, cyc - load_cyc, mem_dir, mem_data_in);
        if (nwe < 16) begin
          we_rel[nwe]  = cyc - load_cyc;
          we_dir[nwe]  = mem_dir;
          we_data[nwe] = mem_data_in;
        end
        writes++;
        nwe++;
      end
      if (done && done_rel < 0) done_rel = cyc - load_cyc;
      if (fifo_rd_en) begin
        expq.push_back(fq[rd_ptr % 1024]);
        pops++;
        if (nrd == 0) rd_first = cyc - load_cyc;
        nrd++;
      end
      prev_rd = fifo_rd_en;
      if (start && !e_busy) begin
        started = 1'b1; pops = 0; writes = 0;
        expq.delete();
        load_cyc = cyc; nwe = 0; nrd = 0; rd_first = -1; done_rel = -1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random tests -------------------------------
  initial begin
    // Reset values while held in reset.
    repeat (2) @(negedge clk);
    #2;
    chk("t1_busy",    32'(busy),    32'd0);
    chk("t1_cpu_run", 32'(cpu_run), 32'd0);
    chk("t1_dir",     mem_dir,      32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Full load, FIFO never empty.
    for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i));
    pulse_start();
    wait_done(40);
    chk("t2_nwe",      32'(nwe),         32'd8);
    chk("t2_rd_first", 32'(rd_first),    32'd1);
    chk("t2_we0_cyc",  32'(we_rel[0]),   32'd2);
    chk("t2_we7_cyc",  32'(we_rel[7]),   32'd9);
    chk("t2_dir0",     we_dir[0],        32'd0);
    chk("t2_dir7",     we_dir[7],        32'd28);
    chk("t2_data0",    we_data[0],       32'hA0);
    chk("t2_data7",    we_data[7],       32'hA7);
    chk("t2_done_cyc", 32'(done_rel),    32'd10);
    chk("t2_words",    32'(words_loaded), 32'd8);
    chk("t2_cpu_run",  32'(cpu_run),     32'd1);

    // Three-cycle FIFO gap after word 2.
    for (int i = 0; i < 3; i++) push(32'hB0 + 32'(i));
    pulse_start();
    repeat (6) @(negedge clk);
    for (int i = 3; i < 8; i++) push(32'hB0 + 32'(i));
    wait_done(40);
    chk("t3_nwe",   32'(nwe),   32'd8);
    chk("t3_dir3",  we_dir[3],  32'd12);
    chk("t3_data3", we_data[3], 32'hB3);
    chk("t3_stall", 32'((we_rel[3] - we_rel[2]) > 1), 32'd1);

    // Ten words available, only eight consumed.
    for (int i = 0; i < 10; i++) push(32'hC0 + 32'(i));
    pulse_start();
    wait_done(40);
    chk("t4_left", 32'(wr_ptr - rd_ptr), 32'd2);
    chk("t4_nrd",  32'(nrd),            32'd8);
    repeat (3) @(negedge clk);
    chk("t4_left_hold", 32'(wr_ptr - rd_ptr), 32'd2);
    wr_ptr = rd_ptr;

    // start during LOAD is ignored.
    for (int i = 0; i < 8; i++) push(32'hD0 + 32'(i));
    pulse_start();
    repeat (2) @(negedge clk);
    pulse_start();
    wait_done(40);
    chk("t5_nwe",      32'(nwe),      32'd8);
    chk("t5_dir7",     we_dir[7],     32'd28);
    chk("t5_done_cyc", 32'(done_rel), 32'd10);

    // Reset after four writes, then a fresh load from BASE.
    for (int i = 0; i < 8; i++) push(32'hE0 + 32'(i));
    pulse_start();
    begin
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (nwe >= 4) begin ok = 1'b1; break; end
      end
      if (!ok) chk("t6_reach4_timeout", 32'd0, 32'd1);
    end
    #3 rst_n = 1'b0;
    #1;
    chk("t6_busy",  32'(busy),         32'd0);
    chk("t6_run",   32'(cpu_run),      32'd0);
    chk("t6_we",    32'(mem_we),       32'd0);
    chk("t6_words", 32'(words_loaded), 32'd0);
    chk("t6_dir",   mem_dir,           BASE);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    wr_ptr = rd_ptr;
    for (int i = 0; i < 8; i++) push(32'hF0 + 32'(i));
    pulse_start();
    wait_done(40);
    chk("t6_nwe",   32'(nwe),   32'd8);
    chk("t6_dir0",  we_dir[0],  32'd0);
    chk("t6_data0", we_data[0], 32'hF0);

    // Restart from DONE: cpu_run drops the cycle after start.
    for (int i = 0; i < 8; i++) push(32'h100 + 32'(i));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    #2;
    chk("t6_run_drop", 32'(cpu_run), 32'd0);
    wait_done(40);
    chk("t6b_nwe", 32'(nwe), 32'd8);

    // Randomized loads with gaps, trickling pushes and stray start pulses.
    for (int l = 0; l < 6; l++) begin
      bit ok;
      int npre;
      npre = $urandom_range(0, 8);
      for (int i = 0; i < npre; i++) push($urandom);
      @(negedge clk) start = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (done) begin ok = 1'b1; break; end
        gap = (($urandom % 4) == 0);
        if (($urandom % 2) == 1) push($urandom);
        if (($urandom % 12) == 0) start = 1'b1;
      end
      gap = 1'b0;
      start = 1'b0;
      if (!ok) chk("rand_done_timeout", 32'd0, 32'd1);
      #2;
      chk("rand_nwe", 32'(nwe), 32'd8);
    end

    repeat (2) @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_imem_program_loader
